// File: rtl/arb_pkg.sv
// Shared definitions for the request buffer that feeds the 2-agent arbiter.
package arb_pkg;

   localparam int NUM_AGENTS          = 2;
   localparam int PEND_W_DEF          = 3;
   localparam int SERVICE_CYCLES_DEF  = 4;
   localparam int PEND_MAX            = (2 ** PEND_W_DEF) - 1;

   // Per-agent condition, decoded from the pending and service counters
   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,   // nothing pending
      SLOT_WAIT  = 2'd1,   // pending, no granted edges yet in this transaction
      SLOT_SERVE = 2'd2    // part-way through a transaction's granted edges
   } slot_state_e;

   // Width of a service counter that must reach SERVICE_CYCLES; never below 1
   function automatic int svc_width(input int service_cycles);
      int w;
      w = $clog2(service_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/agent_req_slot.sv
// One agent's request slot: pending counter, service counter, done pulse and
// sticky overflow flag. Request level to the arbiter is decoded from pend.
module agent_req_slot
   import arb_pkg::*;
#(
   parameter int PEND_W         = PEND_W_DEF,
   parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              grant_i,
   output logic              req_lvl_o,
   output logic              done_o,
   output logic [PEND_W-1:0] pend_o,
   output logic              overflow_o
);

   localparam int                 SVC_W     = svc_width(SERVICE_CYCLES);
   localparam logic [PEND_W-1:0]  P_MAX     = {PEND_W{1'b1}};
   localparam logic [SVC_W-1:0]   SVC_LAST  = SVC_W'(SERVICE_CYCLES - 1);

   logic [PEND_W-1:0] pend_q, pend_d;
   logic [SVC_W-1:0]  svc_q,  svc_d;
   logic              done_q, done_d;
   logic              ovf_q,  ovf_d;
   slot_state_e       state;
   logic              complete;

   // Decode the slot condition from the counters
   always_comb begin
      state = SLOT_IDLE;
      if (svc_q != '0)
         state = SLOT_SERVE;
      else if (pend_q != '0)
         state = SLOT_WAIT;
   end

   // A granted edge finishes the transaction when the service count is at its last step
   assign complete = grant_i && (state != SLOT_IDLE) && (svc_q == SVC_LAST);

   // Next-state for service counter, pending counter, done pulse and overflow
   always_comb begin
      pend_d = pend_q;
      svc_d  = svc_q;
      done_d = 1'b0;
      ovf_d  = ovf_q;

      // Service: any non-granted edge aborts a partial transaction; grants with
      // nothing pending are ignored
      if (grant_i && (state != SLOT_IDLE)) begin
         if (complete) begin
            svc_d  = '0;
            done_d = 1'b1;
         end else begin
            svc_d = svc_q + 1'b1;
         end
      end else begin
         svc_d = '0;
      end

      // Pending: a same-edge enqueue and completion cancel out, which also lets a
      // full counter accept a request on its completing edge
      unique case ({req_i, complete})
         2'b10: begin
            if (pend_q == P_MAX)
               ovf_d = 1'b1;
            else
               pend_d = pend_q + 1'b1;
         end
         2'b01:   pend_d = pend_q - 1'b1;
         default: pend_d = pend_q;
      endcase
   end

   // Slot registers; reset wins over everything, including a transaction in service
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         svc_q  <= '0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         svc_q  <= svc_d;
         done_q <= done_d;
         ovf_q  <= ovf_d;
      end
   end

   // Request level follows the registered count, so it drops with the last done pulse
   assign req_lvl_o  = (pend_q != '0);
   assign done_o     = done_q;
   assign pend_o     = pend_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/agent_req_buffer.sv
// Request buffer in front of the 2-agent arbiter: one independent slot per
// agent, wired to the arbiter-facing request and grant vectors.
module agent_req_buffer
   import arb_pkg::*;
#(
   parameter int PEND_W         = PEND_W_DEF,
   parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_AGENTS-1:0] req_in,
   input  logic [NUM_AGENTS-1:0] g,
   output logic [NUM_AGENTS-1:0] r,
   output logic [NUM_AGENTS-1:0] done,
   output logic [PEND_W-1:0]     pend0,
   output logic [PEND_W-1:0]     pend1,
   output logic [NUM_AGENTS-1:0] overflow
);

   logic [PEND_W-1:0] pend_w [NUM_AGENTS];

   for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_slot
      agent_req_slot #(
         .PEND_W         (PEND_W),
         .SERVICE_CYCLES (SERVICE_CYCLES)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .req_i      (req_in[i]),
         .grant_i    (g[i]),
         .req_lvl_o  (r[i]),
         .done_o     (done[i]),
         .pend_o     (pend_w[i]),
         .overflow_o (overflow[i])
      );
   end

   assign pend0 = pend_w[0];
   assign pend1 = pend_w[1];

endmodule

// File: tb/tb_agent_req_buffer.sv
// Directed bench for agent_req_buffer at default parameters (8 ns clock).
module tb_agent_req_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_in;
   logic [1:0] g;
   logic [1:0] r;
   logic [1:0] done;
   logic [2:0] pend0;
   logic [2:0] pend1;
   logic [1:0] overflow;

   int vectors     = 0;
   int miscompares = 0;

   // clock / reset block
   always #4 clk = ~clk;

   agent_req_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .g        (g),
      .r        (r),
      .done     (done),
      .pend0    (pend0),
      .pend1    (pend1),
      .overflow (overflow)
   );

   // scoreboard check
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver: apply current inputs across one rising edge, settle after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] rq, input logic [1:0] gr);
      req_in = rq;
      g      = gr;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'b00, 2'b00);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      req_in = 2'b00;
      g      = 2'b00;

      // 1. reset with random inputs
      for (int i = 0; i < 2; i++) drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      rst = 1'b0;
      req_in = 2'b00;
      g = 2'b00;
      check("rst_r", r, 2'b00);
      check("rst_done", done, 2'b00);
      check("rst_pend0", pend0, 3'd0);
      check("rst_pend1", pend1, 3'd0);
      check("rst_ovf", overflow, 2'b00);

      // 2. single request, held without grant, then served
      drive(2'b01, 2'b00);
      check("t2_pend0", pend0, 3'd1);
      check("t2_r", r, 2'b01);
      for (int i = 0; i < 5; i++) begin
         drive(2'b00, 2'b00);
         check("t2_hold_r", r, 2'b01);
         check("t2_hold_done", done, 2'b00);
      end
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 2'b01);
         check("t2_svc_done", done, 2'b00);
         check("t2_svc_r", r, 2'b01);
      end
      drive(2'b00, 2'b01);
      check("t2_done", done, 2'b01);
      check("t2_r_drop", r, 2'b00);
      check("t2_pend0_0", pend0, 3'd0);
      drive(2'b00, 2'b00);
      check("t2_done_pulse", done, 2'b00);

      // 3. aborted service restarts from zero
      drive(2'b01, 2'b00);
      check("t3_pend0", pend0, 3'd1);
      drive(2'b00, 2'b01);
      drive(2'b00, 2'b01);
      drive(2'b00, 2'b00);
      check("t3_abort_done", done, 2'b00);
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 2'b01);
         check("t3_rerun_done", done, 2'b00);
         check("t3_rerun_pend", pend0, 3'd1);
      end
      drive(2'b00, 2'b01);
      check("t3_done", done, 2'b01);
      check("t3_pend0_0", pend0, 3'd0);
      drive(2'b00, 2'b00);

      // 4. overflow on agent 1
      for (int k = 1; k <= 7; k++) begin
         drive(2'b10, 2'b00);
         check("t4_pend1", pend1, 32'(k));
         check("t4_no_ovf", overflow, 2'b00);
      end
      drive(2'b10, 2'b00);
      check("t4_pend1_sat", pend1, 3'd7);
      check("t4_ovf", overflow, 2'b10);
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 2'b00);
         check("t4_ovf_sticky", overflow, 2'b10);
      end
      do_reset();
      check("t4_rst_ovf", overflow, 2'b00);
      check("t4_rst_pend1", pend1, 3'd0);

      // 5. same-edge enqueue and completion
      drive(2'b01, 2'b00);
      drive(2'b01, 2'b00);
      check("t5_pend0_2", pend0, 3'd2);
      for (int i = 0; i < 3; i++) drive(2'b00, 2'b01);
      drive(2'b01, 2'b01);
      check("t5_sim_done", done, 2'b01);
      check("t5_sim_pend", pend0, 3'd2);
      for (int i = 0; i < 5; i++) drive(2'b01, 2'b00);
      check("t5_full", pend0, 3'd7);
      for (int i = 0; i < 3; i++) drive(2'b00, 2'b01);
      drive(2'b01, 2'b01);
      check("t5_full_done", done, 2'b01);
      check("t5_full_pend", pend0, 3'd7);
      check("t5_full_ovf", overflow, 2'b00);
      do_reset();

      // 6. both agents served in turn, then reset mid-service
      drive(2'b11, 2'b00);
      check("t6_r11", r, 2'b11);
      for (int i = 0; i < 4; i++) drive(2'b00, 2'b01);
      check("t6_done0", done, 2'b01);
      check("t6_r10", r, 2'b10);
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 2'b10);
         check("t6_wait1", done, 2'b00);
      end
      drive(2'b00, 2'b10);
      check("t6_done1", done, 2'b10);
      check("t6_r00", r, 2'b00);
      drive(2'b00, 2'b00);
      drive(2'b10, 2'b00);
      drive(2'b00, 2'b10);
      drive(2'b00, 2'b10);
      rst = 1'b1;
      drive(2'b00, 2'b10);
      rst = 1'b0;
      check("t6_rst_pend1", pend1, 3'd0);
      check("t6_rst_r", r, 2'b00);
      check("t6_rst_done", done, 2'b00);
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 2'b10);
         check("t6_post_rst_done", done, 2'b00);
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
